// File: rtl/drp_wb.sv
// DRP responder that turns each DRP access into one classic Wishbone master cycle.
// A watchdog aborts an unanswered cycle, so every DRP access ends with drp_rdy.
module drp_wb #(
   parameter int ADDR_WIDTH = 16,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] drp_addr,
   input  logic [15:0]           drp_di,
   input  logic                  drp_we,
   input  logic                  drp_en,
   output logic [15:0]           drp_do,
   output logic                  drp_rdy,
   output logic [ADDR_WIDTH-1:0] wb_adr_o,
   output logic [15:0]           wb_dat_o,
   input  logic [15:0]           wb_dat_i,
   output logic                  wb_we_o,
   output logic [1:0]            wb_sel_o,
   output logic                  wb_stb_o,
   output logic                  wb_cyc_o,
   input  logic                  wb_ack_i,
   input  logic                  wb_err_i,
   output logic                  busy,
   output logic                  err_o,
   output logic                  overrun
);

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_CYCLE = 1'b1;

   logic                  state_q, state_d;
   logic [ADDR_WIDTH-1:0] adr_q, adr_d;
   logic [15:0]           dat_q, dat_d;
   logic                  we_q, we_d;
   logic                  cyc_q, cyc_d;
   logic                  rdy_q, rdy_d;
   logic                  err_q, err_d;
   logic [15:0]           do_q, do_d;
   logic                  ovr_q, ovr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic wdog_s;
   logic done_s;
   logic fail_s;

   // An access ends on ack, err or watchdog expiry; err wins over ack, and expiry
   // without any response is treated like an err.
   assign wdog_s = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
   assign done_s = (state_q == ST_CYCLE) && (wb_ack_i || wb_err_i || wdog_s);
   assign fail_s = wb_err_i || !wb_ack_i;

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         adr_q   <= '0;
         dat_q   <= 16'h0000;
         we_q    <= 1'b0;
         cyc_q   <= 1'b0;
         rdy_q   <= 1'b0;
         err_q   <= 1'b0;
         do_q    <= 16'h0000;
         ovr_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         we_q    <= we_d;
         cyc_q   <= cyc_d;
         rdy_q   <= rdy_d;
         err_q   <= err_d;
         do_q    <= do_d;
         ovr_q   <= ovr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (drp_en) begin
               state_d = ST_CYCLE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CYCLE: begin
            if (done_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_CYCLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output and datapath next values.
   always_comb begin
      adr_d = adr_q;
      dat_d = dat_q;
      we_d  = we_q;
      cyc_d = cyc_q;
      rdy_d = 1'b0;
      err_d = 1'b0;
      do_d  = do_q;
      cnt_d = cnt_q;
      ovr_d = ovr_q;
      case (state_q)
         ST_IDLE: begin
            if (drp_en) begin
               adr_d = drp_addr;
               dat_d = drp_di;
               we_d  = drp_we;
               cyc_d = 1'b1;
               cnt_d = '0;
            end else begin
               cyc_d = 1'b0;
            end
         end
         ST_CYCLE: begin
            // A new strobe while busy is dropped but remembered.
            if (drp_en) begin
               ovr_d = 1'b1;
            end else begin
               ovr_d = ovr_q;
            end
            if (done_s) begin
               cyc_d = 1'b0;
               rdy_d = 1'b1;
               err_d = fail_s;
               if (!we_q) begin
                  do_d = fail_s ? 16'h0000 : wb_dat_i;
               end else begin
                  do_d = do_q;
               end
            end else begin
               cyc_d = 1'b1;
               cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            end
         end
         default: begin
            cyc_d = 1'b0;
         end
      endcase
   end

   assign drp_do   = do_q;
   assign drp_rdy  = rdy_q;
   assign wb_adr_o = adr_q;
   assign wb_dat_o = dat_q;
   assign wb_we_o  = we_q;
   assign wb_sel_o = 2'b11;
   assign wb_stb_o = cyc_q;
   assign wb_cyc_o = cyc_q;
   assign busy     = cyc_q;
   assign err_o    = err_q;
   assign overrun  = ovr_q;

endmodule

// File: tb/tb_drp_wb.sv
// Directed plus randomized bench for drp_wb; expectations come from a transaction-level
// model (latency = min(wait+1, TIMEOUT)+1, data/err from the response kind).
module tb_drp_wb;
   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] drp_addr = 16'h0000;
   logic [15:0] drp_di = 16'h0000;
   logic        drp_we = 1'b0;
   logic        drp_en = 1'b0;
   logic [15:0] drp_do;
   logic        drp_rdy;
   logic [15:0] wb_adr_o;
   logic [15:0] wb_dat_o;
   logic [15:0] wb_dat_i = 16'h0000;
   logic        wb_we_o;
   logic [1:0]  wb_sel_o;
   logic        wb_stb_o;
   logic        wb_cyc_o;
   logic        wb_ack_i = 1'b0;
   logic        wb_err_i = 1'b0;
   logic        busy;
   logic        err_o;
   logic        overrun;

   int checks = 0;
   int failures = 0;
   logic [15:0] exp_do = 16'h0000;
   logic        exp_ovr = 1'b0;

   drp_wb #(.ADDR_WIDTH(16), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .drp_addr(drp_addr), .drp_di(drp_di), .drp_we(drp_we), .drp_en(drp_en),
      .drp_do(drp_do), .drp_rdy(drp_rdy),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
      .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
      .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
      .busy(busy), .err_o(err_o), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cyc"}, 32'(wb_cyc_o), 32'd0);
      check({tag, "_stb"}, 32'(wb_stb_o), 32'd0);
      check({tag, "_we"}, 32'(wb_we_o), 32'd0);
      check({tag, "_rdy"}, 32'(drp_rdy), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_err"}, 32'(err_o), 32'd0);
      check({tag, "_ovr"}, 32'(overrun), 32'd0);
      check({tag, "_do"}, 32'(drp_do), 32'd0);
      check({tag, "_adr"}, 32'(wb_adr_o), 32'd0);
      check({tag, "_dat"}, 32'(wb_dat_o), 32'd0);
      check({tag, "_sel"}, 32'(wb_sel_o), 32'd3);
   endtask

   // One idle cycle with garbage on wb_dat_i; nothing may complete.
   task automatic idle_cycle();
      wb_dat_i = 16'($urandom);
      @(negedge clk);
      check("idle_rdy", 32'(drp_rdy), 32'd0);
      check("idle_err", 32'(err_o), 32'd0);
      check("idle_cyc", 32'(wb_cyc_o), 32'd0);
      check("idle_ovr", 32'(overrun), 32'(exp_ovr));
   endtask

   // Issues one DRP access at the current negedge and plays the slave: responds
   // after 'delay' wait cycles (ack or err), optionally pulses drp_en at wait
   // cycle 'ovr_at'. Returns at the negedge where drp_rdy is visible.
   task automatic access(input logic we, input logic [15:0] addr, input logic [15:0] di,
                         input int delay, input bit use_err, input logic [15:0] rdata,
                         input int ovr_at);
      int  lat;
      int  exp_lat;
      bit  aborted;
      bit  got;
      drp_en = 1'b1; drp_we = we; drp_addr = addr; drp_di = di;
      @(negedge clk);
      drp_en = 1'b0; drp_addr = 16'($urandom); drp_di = 16'($urandom); drp_we = 1'($urandom);
      check("start_cyc", 32'(wb_cyc_o), 32'd1);
      check("start_stb", 32'(wb_stb_o), 32'd1);
      check("start_busy", 32'(busy), 32'd1);
      check("start_adr", 32'(wb_adr_o), 32'(addr));
      check("start_dat", 32'(wb_dat_o), 32'(di));
      check("start_we", 32'(wb_we_o), 32'(we));
      check("start_sel", 32'(wb_sel_o), 32'd3);
      check("start_rdy", 32'(drp_rdy), 32'd0);
      aborted = (delay + 1 > TO);
      exp_lat = aborted ? TO + 1 : delay + 2;
      lat = 1;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         if (i == ovr_at) begin
            drp_en = 1'b1;
            exp_ovr = 1'b1;
         end
         if (i == delay) begin
            if (use_err) wb_err_i = 1'b1;
            else         wb_ack_i = 1'b1;
            wb_dat_i = rdata;
         end else begin
            wb_dat_i = 16'($urandom);
         end
         @(negedge clk);
         lat++;
         drp_en = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
         if (drp_rdy) begin
            got = 1'b1;
         end else begin
            check("wait_cyc", 32'(wb_cyc_o), 32'd1);
            check("wait_adr", 32'(wb_adr_o), 32'(addr));
            check("wait_err", 32'(err_o), 32'd0);
         end
      end
      check("rdy_seen", 32'(got), 32'd1);
      check("latency", 32'(lat), 32'(exp_lat));
      check("done_cyc", 32'(wb_cyc_o), 32'd0);
      check("done_stb", 32'(wb_stb_o), 32'd0);
      check("done_busy", 32'(busy), 32'd0);
      check("done_err", 32'(err_o), 32'(aborted || use_err));
      if (!we) exp_do = (aborted || use_err) ? 16'h0000 : rdata;
      check("done_do", 32'(drp_do), 32'(exp_do));
      check("done_ovr", 32'(overrun), 32'(exp_ovr));
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      idle_cycle();

      // Write, acked in the first strobe cycle.
      access(1'b1, 16'h0042, 16'hBEEF, 0, 1'b0, 16'h0000, -1);
      idle_cycle();
      // Read with five wait states.
      access(1'b0, 16'h0010, 16'h0000, 5, 1'b0, 16'h1234, -1);
      idle_cycle();
      // Read terminated by wb_err_i.
      access(1'b0, 16'h0020, 16'h0000, 2, 1'b1, 16'h5555, -1);
      idle_cycle();
      // A write must leave drp_do alone; then a read that times out.
      access(1'b0, 16'h0030, 16'h0000, 1, 1'b0, 16'hC0DE, -1);
      access(1'b1, 16'h0031, 16'h1111, 1, 1'b0, 16'hFFFF, -1);
      idle_cycle();
      access(1'b0, 16'h0040, 16'h0000, 20, 1'b0, 16'hAAAA, -1);
      idle_cycle();
      // Back-to-back: second drp_en in the drp_rdy cycle, no overrun.
      access(1'b1, 16'h0050, 16'h2222, 0, 1'b0, 16'h0000, -1);
      access(1'b0, 16'h0051, 16'h0000, 0, 1'b0, 16'hA5A5, -1);
      check("b2b_ovr", 32'(overrun), 32'd0);
      idle_cycle();
      // Overrun: drp_en during the cycle is ignored, flag is sticky.
      access(1'b0, 16'h0060, 16'h0000, 4, 1'b0, 16'h7777, 1);
      repeat (3) idle_cycle();

      // Reset in the middle of a cycle.
      drp_en = 1'b1; drp_we = 1'b0; drp_addr = 16'h0070; drp_di = 16'h0000;
      @(negedge clk);
      drp_en = 1'b0;
      @(negedge clk);
      check("midrst_cyc_before", 32'(wb_cyc_o), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs("midrst");
      rst_n = 1'b1;
      exp_do = 16'h0000; exp_ovr = 1'b0;
      repeat (2) idle_cycle();

      // Randomized accesses against the transaction model.
      for (int n = 0; n < 40; n++) begin
         int gap;
         int dly;
         int ovr;
         gap = int'($urandom_range(0, 2));
         dly = int'($urandom_range(0, 10));
         ovr = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 10)) : -1;
         if (ovr > dly) ovr = -1;
         if (dly + 1 > TO && ovr > TO - 1) ovr = -1;
         for (int g = 0; g < gap; g++) idle_cycle();
         access(1'($urandom), 16'($urandom), 16'($urandom), dly,
                ($urandom_range(0, 3) == 0), 16'($urandom), ovr);
      end
      idle_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
